// File: rtl/store_align_buffer.sv
// Store path between core and data memory: lane alignment, byte strobes, illegal-store
// detection, a DEPTH-entry store FIFO drained over valid/ready, and load-after-store hazard.
module store_align_buffer #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_st_valid,
   output logic                       o_st_ready,
   input  logic [2:0]                 i_st_op,
   input  logic [ADDR_W-1:0]          i_st_addr,
   input  logic [XLEN-1:0]            i_st_data,
   output logic                       o_mem_valid,
   input  logic                       i_mem_ready,
   output logic [ADDR_W-1:0]          o_mem_addr,
   output logic [XLEN-1:0]            o_mem_wdata,
   output logic [XLEN/8-1:0]          o_mem_wstrb,
   input  logic [ADDR_W-1:0]          i_ld_addr,
   output logic                       o_ld_hazard,
   output logic                       o_misalign_err,
   output logic [ADDR_W-1:0]          o_err_addr,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int NB = XLEN / 8;
   localparam int L  = $clog2(NB);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [2:0]    OP_SB   = 3'b000;
   localparam logic [2:0]    OP_SH   = 3'b001;
   localparam logic [2:0]    OP_SW   = 3'b010;
   localparam logic [2:0]    OP_SD   = 3'b011;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [L-1:0]      w_lane;
   logic [NB-1:0]     w_base;
   logic [XLEN-1:0]   w_mask;
   logic [XLEN-1:0]   w_wdata;
   logic [NB-1:0]     w_wstrb;
   logic [ADDR_W-1:0] w_word_addr;
   logic              w_illegal;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_hazard;

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [XLEN-1:0]   r_data [DEPTH];
   logic [NB-1:0]     r_strb [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_err;
   logic [ADDR_W-1:0] r_err_addr;

   // Decode the store size into a strobe base and flag illegal ops / misalignment.
   always_comb begin
      w_base    = '0;
      w_illegal = 1'b0;
      case (i_st_op)
         OP_SB: begin
            w_base    = NB'(8'h01);
            w_illegal = 1'b0;
         end
         OP_SH: begin
            w_base    = NB'(8'h03);
            w_illegal = i_st_addr[0];
         end
         OP_SW: begin
            w_base    = NB'(8'h0F);
            w_illegal = (i_st_addr[1:0] != 2'b00);
         end
         OP_SD: begin
            w_base    = '1;
            w_illegal = (XLEN != 64) || (i_st_addr[2:0] != 3'b000);
         end
         default: begin
            w_base    = '0;
            w_illegal = 1'b1;
         end
      endcase
   end

   // Shift size-masked data and strobes into their byte lanes.
   always_comb begin
      w_mask = '0;
      for (int b = 0; b < NB; b++) begin
         w_mask[8*b +: 8] = {8{w_base[b]}};
      end
      w_lane      = i_st_addr[L-1:0];
      w_wdata     = (i_st_data & w_mask) << {w_lane, 3'b000};
      w_wstrb     = w_base << w_lane;
      w_word_addr = {i_st_addr[ADDR_W-1:L], {L{1'b0}}};
   end

   assign o_st_ready  = (r_count != CNT_MAX);
   assign o_mem_valid = (r_count != '0);
   assign w_accept    = i_st_valid && o_st_ready;
   assign w_push      = w_accept && !w_illegal;
   assign w_pop       = o_mem_valid && i_mem_ready;

   // FIFO storage, pointers, occupancy and the illegal-store error report.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_strb[i] <= '0;
         end
         r_vld      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + PTR_ONE;
         end
         // Push slot never equals the pop slot: push needs non-full, pop needs non-empty.
         if (w_push) begin
            r_vld[r_wr_ptr]  <= 1'b1;
            r_addr[r_wr_ptr] <= w_word_addr;
            r_data[r_wr_ptr] <= w_wdata;
            r_strb[r_wr_ptr] <= w_wstrb;
            r_wr_ptr         <= r_wr_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         r_err <= w_accept && w_illegal;
         if (w_accept && w_illegal) begin
            r_err_addr <= i_st_addr;
         end else begin
            r_err_addr <= r_err_addr;
         end
      end
   end

   // Word-granular match of the load address against every occupied entry.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && ((r_addr[i] >> L) == (i_ld_addr >> L))) begin
            w_hazard = 1'b1;
         end else begin
            w_hazard = w_hazard;
         end
      end
   end

   assign o_ld_hazard    = w_hazard;
   assign o_mem_addr     = r_addr[r_rd_ptr];
   assign o_mem_wdata    = r_data[r_rd_ptr];
   assign o_mem_wstrb    = r_strb[r_rd_ptr];
   assign o_misalign_err = r_err;
   assign o_err_addr     = r_err_addr;
   assign o_count        = r_count;

endmodule
